pe_mac_seq: RTL and testbench

// - Sequential multiply-accumulate processing element: dot product of two DATA_W vectors held in shared RAM.
// - Generalised successor to the single-cycle PE:
//   - explicit start/busy/done handshake; one memory port instead of direct RAM access;
//   - strided operands; parametrised multiplier latency; selectable saturation; overflow flag.
// - Instanced per lane by the matrix-multiply controller; writes one result word per started operation.

---
 rtl/pe_pkg.sv | 31 +++
 rtl/pe_mac_seq_if.sv | 34 +++
 rtl/pe_mult_pipe.sv | 39 +++
 rtl/pe_mac_seq.sv | 148 ++++++++++++++
 tb/tb_pe_mac_seq.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/pe_pkg.sv
// Shared types and helpers for the sequential MAC processing element.
package pe_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD_L,
        S_RD_R,
        S_MUL,
        S_ACC,
        S_WR,
        S_DONE
    } pe_state_e;

    localparam int MAX_MULT_LAT = 4;
    localparam int MAX_ACC_W    = 128;

    // Clamp a wide signed value into the signed range of a data_w-bit word.
    function automatic logic signed [MAX_ACC_W-1:0] sat_clamp(
        input logic signed [MAX_ACC_W-1:0] v,
        input int                          data_w
    );
        logic signed [MAX_ACC_W-1:0] hi;
        logic signed [MAX_ACC_W-1:0] lo;
        hi = (MAX_ACC_W'(1) << (data_w - 1)) - MAX_ACC_W'(1);
        lo = ~hi;
        if (v > hi) return hi;
        if (v < lo) return lo;
        return v;
    endfunction

endpackage

// File: rtl/pe_mac_seq_if.sv
// Control handshake plus single memory port of one MAC processing element.
interface pe_mac_seq_if #(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 32,
    parameter int LEN_W  = 16
);
    logic              start;
    logic [ADDR_W-1:0] left_base;
    logic [ADDR_W-1:0] right_base;
    logic [ADDR_W-1:0] left_stride;
    logic [ADDR_W-1:0] right_stride;
    logic [ADDR_W-1:0] result_addr;
    logic [LEN_W-1:0]  vec_len;
    logic              busy;
    logic              done;
    logic              overflow;
    logic              mem_re;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata;

    modport slave (
        input  start, left_base, right_base, left_stride, right_stride,
               result_addr, vec_len, mem_rdata,
        output busy, done, overflow, mem_re, mem_we, mem_addr, mem_wdata
    );

    modport master (
        output start, left_base, right_base, left_stride, right_stride,
               result_addr, vec_len, mem_rdata,
        input  busy, done, overflow, mem_re, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/pe_mult_pipe.sv
// Signed DATA_W x DATA_W multiplier with MULT_LAT register stages and a valid shadow.
module pe_mult_pipe #(
    parameter int DATA_W   = 32,
    parameter int MULT_LAT = 1
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       vld_in,
    input  logic signed [DATA_W-1:0]   a,
    input  logic signed [DATA_W-1:0]   b,
    output logic                       vld_out,
    output logic signed [2*DATA_W-1:0] prod
);
    localparam int P_W = 2 * DATA_W;

    logic [MULT_LAT:0]     vld_pipe;
    logic [MULT_LAT:1]     vld_q;
    logic signed [P_W-1:0] a_ext;
    logic signed [P_W-1:0] b_ext;
    logic signed [P_W-1:0] prod_q [1:MULT_LAT];

    assign a_ext    = P_W'(a);
    assign b_ext    = P_W'(b);
    assign vld_pipe = {vld_q, vld_in};

    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q <= '0;
            for (int i = 1; i <= MULT_LAT; i++) prod_q[i] <= '0;
        end else begin
            for (int i = 1; i <= MULT_LAT; i++) vld_q[i] <= vld_pipe[i-1];
            prod_q[1] <= a_ext * b_ext;
            for (int i = 2; i <= MULT_LAT; i++) prod_q[i] <= prod_q[i-1];
        end
    end

    assign vld_out = vld_pipe[MULT_LAT];
    assign prod    = prod_q[MULT_LAT];
endmodule

// File: rtl/pe_mac_seq.sv
// Sequential dot-product PE: reads strided operand pairs through one memory port,
// accumulates signed products and writes one (optionally saturated) result word.
module pe_mac_seq
    import pe_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int ADDR_W   = 32,
    parameter int ACC_W    = 64,
    parameter int LEN_W    = 16,
    parameter int MULT_LAT = 1,
    parameter int SATURATE = 0
) (
    input logic         clk,
    input logic         rst,
    pe_mac_seq_if.slave bus
);
    localparam int              MC_W     = $clog2(MAX_MULT_LAT);
    localparam logic [MC_W-1:0] MUL_LAST = MC_W'(MULT_LAT - 1);

    pe_state_e                   state;
    logic [ADDR_W-1:0]           l_ptr, r_ptr, l_stride, r_stride, res_addr;
    logic [LEN_W-1:0]            len, cnt, cnt_nxt;
    logic [MC_W-1:0]             mul_cnt;
    logic signed [DATA_W-1:0]    l_op;
    logic signed [2*DATA_W-1:0]  prod;
    logic signed [ACC_W-1:0]     acc, prod_ext, acc_nxt;
    logic signed [MAX_ACC_W-1:0] acc_wide, acc_clamp;
    logic [DATA_W-1:0]           result;
    logic                        mul_issue, prod_vld, add_ovf, range_ovf;

    // Right operand arrives on mem_rdata during the first MUL cycle and feeds the pipe directly.
    assign mul_issue = (state == S_MUL) && (mul_cnt == '0);

    pe_mult_pipe #(.DATA_W(DATA_W), .MULT_LAT(MULT_LAT)) u_mult (
        .clk     (clk),
        .rst     (rst),
        .vld_in  (mul_issue),
        .a       (l_op),
        .b       (bus.mem_rdata),
        .vld_out (prod_vld),
        .prod    (prod)
    );

    assign prod_ext  = ACC_W'(prod);
    assign acc_nxt   = acc + prod_ext;
    assign add_ovf   = (acc[ACC_W-1] == prod_ext[ACC_W-1]) && (acc_nxt[ACC_W-1] != acc[ACC_W-1]);
    assign acc_wide  = MAX_ACC_W'(acc_nxt);
    assign acc_clamp = sat_clamp(acc_wide, DATA_W);
    assign range_ovf = (acc_clamp != acc_wide);
    assign result    = (SATURATE != 0) ? acc_clamp[DATA_W-1:0] : acc_nxt[DATA_W-1:0];
    assign cnt_nxt   = cnt + 1'b1;

    // Memory strobes are registered: they are set on entry to the state that owns them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= S_IDLE;
            l_ptr         <= '0;
            r_ptr         <= '0;
            l_stride      <= '0;
            r_stride      <= '0;
            res_addr      <= '0;
            len           <= '0;
            cnt           <= '0;
            mul_cnt       <= '0;
            l_op          <= '0;
            acc           <= '0;
            bus.busy      <= 1'b0;
            bus.done      <= 1'b0;
            bus.overflow  <= 1'b0;
            bus.mem_re    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            bus.mem_re    <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
            bus.done      <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        l_ptr        <= bus.left_base;
                        r_ptr        <= bus.right_base;
                        l_stride     <= bus.left_stride;
                        r_stride     <= bus.right_stride;
                        res_addr     <= bus.result_addr;
                        len          <= bus.vec_len;
                        cnt          <= '0;
                        acc          <= '0;
                        bus.overflow <= 1'b0;
                        bus.busy     <= 1'b1;
                        if (bus.vec_len == '0) begin
                            state        <= S_WR;
                            bus.mem_we   <= 1'b1;
                            bus.mem_addr <= bus.result_addr;
                        end else begin
                            state        <= S_RD_L;
                            bus.mem_re   <= 1'b1;
                            bus.mem_addr <= bus.left_base;
                        end
                    end
                end
                S_RD_L: begin
                    state        <= S_RD_R;
                    bus.mem_re   <= 1'b1;
                    bus.mem_addr <= r_ptr;
                end
                S_RD_R: begin
                    l_op    <= bus.mem_rdata;
                    mul_cnt <= '0;
                    state   <= S_MUL;
                end
                S_MUL: begin
                    mul_cnt <= mul_cnt + 1'b1;
                    if (mul_cnt == MUL_LAST) state <= S_ACC;
                end
                S_ACC: begin
                    if (prod_vld) begin
                        acc   <= acc_nxt;
                        cnt   <= cnt_nxt;
                        l_ptr <= l_ptr + l_stride;
                        r_ptr <= r_ptr + r_stride;
                        if (add_ovf) bus.overflow <= 1'b1;
                        if (cnt_nxt == len) begin
                            state         <= S_WR;
                            bus.mem_we    <= 1'b1;
                            bus.mem_addr  <= res_addr;
                            bus.mem_wdata <= result;
                            if (range_ovf) bus.overflow <= 1'b1;
                        end else begin
                            state        <= S_RD_L;
                            bus.mem_re   <= 1'b1;
                            bus.mem_addr <= l_ptr + l_stride;
                        end
                    end
                end
                S_WR: begin
                    state    <= S_DONE;
                    bus.busy <= 1'b0;
                    bus.done <= 1'b1;
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_pe_mac_seq.sv
// Directed bench for pe_mac_seq: two instances (MULT_LAT=1/SATURATE=0 and MULT_LAT=3/SATURATE=1)
// sharing a word RAM model; result writes are checked against a scoreboard queue.
module tb_pe_mac_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    pe_mac_seq_if #(.DATA_W(32), .ADDR_W(32), .LEN_W(16)) bus_a ();
    pe_mac_seq_if #(.DATA_W(32), .ADDR_W(32), .LEN_W(16)) bus_b ();

    pe_mac_seq #(.MULT_LAT(1), .SATURATE(0)) dut_a (.clk(clk), .rst(rst), .bus(bus_a));
    pe_mac_seq #(.MULT_LAT(3), .SATURATE(1)) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

    typedef struct {
        int          sel;
        logic [31:0] addr;
        logic [31:0] data;
    } exp_t;

    logic [31:0] ram [0:255];
    exp_t        exp_q [$];
    logic [31:0] rd_log [$];
    int          total_cnt = 0;
    int          pass_cnt  = 0;
    int          fail_cnt  = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total_cnt++;
        assert (obs === exp) pass_cnt++;
        else begin
            fail_cnt++;
            $error("FAIL %s: observed 0x%0h required 0x%0h", tag, obs, exp);
        end
    endtask

    // RAM model: read data valid the cycle after mem_re.
    always @(posedge clk) begin
        bus_a.mem_rdata <= bus_a.mem_re ? ram[bus_a.mem_addr[7:0]] : 32'hBAD0_BAD0;
        bus_b.mem_rdata <= bus_b.mem_re ? ram[bus_b.mem_addr[7:0]] : 32'hBAD0_BAD0;
        if (bus_a.mem_we) ram[bus_a.mem_addr[7:0]] <= bus_a.mem_wdata;
        if (bus_b.mem_we) ram[bus_b.mem_addr[7:0]] <= bus_b.mem_wdata;
    end

    task automatic mon(input int sel, input logic re, input logic we,
                       input logic [31:0] addr, input logic [31:0] wdata);
        exp_t e;
        check("re_we_exclusive", {63'd0, re & we}, 64'd0);
        if (!re && !we) check("addr_zero_idle", {32'd0, addr}, 64'd0);
        if (re) rd_log.push_back(addr);
        if (we) begin
            check("write_expected", {63'd0, exp_q.size() > 0}, 64'd1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("wr_dut", 64'(sel), 64'(e.sel));
                check("wr_addr", {32'd0, addr}, {32'd0, e.addr});
                check("wr_data", {32'd0, wdata}, {32'd0, e.data});
            end
        end
    endtask

    always @(negedge clk) begin
        mon(0, bus_a.mem_re, bus_a.mem_we, bus_a.mem_addr, bus_a.mem_wdata);
        mon(1, bus_b.mem_re, bus_b.mem_we, bus_b.mem_addr, bus_b.mem_wdata);
    end

    function automatic logic busy_of(input int sel);
        return (sel != 0) ? bus_b.busy : bus_a.busy;
    endfunction
    function automatic logic done_of(input int sel);
        return (sel != 0) ? bus_b.done : bus_a.done;
    endfunction
    function automatic logic ovf_of(input int sel);
        return (sel != 0) ? bus_b.overflow : bus_a.overflow;
    endfunction

    task automatic set_cfg(input logic [31:0] lb, input logic [31:0] rb, input logic [31:0] ls,
                           input logic [31:0] rs, input logic [31:0] ra, input logic [15:0] len);
        bus_a.left_base = lb;  bus_a.right_base = rb;  bus_a.left_stride = ls;
        bus_a.right_stride = rs; bus_a.result_addr = ra; bus_a.vec_len = len;
        bus_b.left_base = lb;  bus_b.right_base = rb;  bus_b.left_stride = ls;
        bus_b.right_stride = rs; bus_b.result_addr = ra; bus_b.vec_len = len;
    endtask

    // Called at a negedge; start is sampled at the next posedge (cycle 0).
    task automatic run_op(input string tag, input int sel,
                          input logic [31:0] lb, input logic [31:0] rb, input logic [31:0] ls,
                          input logic [31:0] rs, input logic [31:0] ra, input logic [15:0] len,
                          input logic [31:0] exp_data, input logic exp_ovf, input int exp_cyc,
                          input bit hold_start);
        exp_t e;
        int   cyc;
        bit   seen;
        e.sel = sel; e.addr = ra; e.data = exp_data;
        exp_q.push_back(e);
        rd_log.delete();
        set_cfg(lb, rb, ls, rs, ra, len);
        if (sel != 0) bus_b.start = 1'b1; else bus_a.start = 1'b1;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 300) begin
            @(negedge clk);
            cyc++;
            if (!hold_start) begin bus_a.start = 1'b0; bus_b.start = 1'b0; end
            if (cyc == 1) check({tag, "_busy_c1"}, {63'd0, busy_of(sel)}, 64'd1);
            if (done_of(sel)) seen = 1'b1;
        end
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        check({tag, "_done_seen"}, {63'd0, seen}, 64'd1);
        check({tag, "_done_cycle"}, 64'(cyc), 64'(exp_cyc));
        check({tag, "_busy_at_done"}, {63'd0, busy_of(sel)}, 64'd0);
        check({tag, "_overflow"}, {63'd0, ovf_of(sel)}, {63'd0, exp_ovf});
        check({tag, "_sb_drained"}, 64'(exp_q.size()), 64'd0);
        check({tag, "_ram"}, {32'd0, ram[ra[7:0]]}, {32'd0, exp_data});
        @(negedge clk);
        check({tag, "_done_pulse"}, {63'd0, done_of(sel)}, 64'd0);
    endtask

    task automatic check_reads(input string tag, input logic [31:0] lb, input logic [31:0] rb,
                               input logic [31:0] ls, input logic [31:0] rs, input int len);
        check({tag, "_rd_count"}, 64'(rd_log.size()), 64'(2 * len));
        if (rd_log.size() == 2 * len)
            for (int k = 0; k < len; k++) begin
                check({tag, "_rd_left"},  {32'd0, rd_log[2*k]},   {32'd0, lb + 32'(k) * ls});
                check({tag, "_rd_right"}, {32'd0, rd_log[2*k+1]}, {32'd0, rb + 32'(k) * rs});
            end
    endtask

    initial begin
        int seen_done;
        int seen_we;
        rst = 1'b1;
        bus_a.start = 1'b0;
        bus_b.start = 1'b0;
        set_cfg(0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 256; i++) ram[i] = 32'hDEAD_0000 | 32'(i);

        repeat (3) @(negedge clk);
        check("rst_flags_a", {59'd0, bus_a.busy, bus_a.done, bus_a.overflow, bus_a.mem_re, bus_a.mem_we}, 64'd0);
        check("rst_flags_b", {59'd0, bus_b.busy, bus_b.done, bus_b.overflow, bus_b.mem_re, bus_b.mem_we}, 64'd0);
        check("rst_addr_data_a", {bus_a.mem_addr, bus_a.mem_wdata}, 64'd0);
        rst = 1'b0;
        @(negedge clk);
        check("idle_busy_a", {63'd0, bus_a.busy}, 64'd0);

        // Basic dot product: 1*5+2*6+3*7+4*8 = 70
        for (int k = 0; k < 4; k++) begin
            ram[8'h10 + k] = 32'(k + 1);
            ram[8'h20 + k] = 32'(k + 5);
        end
        run_op("basic_a", 0, 32'h10, 32'h20, 1, 1, 32'h30, 4, 32'd70, 1'b0, 18, 1'b0);
        check_reads("basic_a", 32'h10, 32'h20, 1, 1, 4);
        run_op("basic_b", 1, 32'h10, 32'h20, 1, 1, 32'h31, 4, 32'd70, 1'b0, 26, 1'b0);

        // Strided: 3*9 + (-7)*4 + 11*(-2) = -23; neighbours hold junk
        ram[8'h40] = 32'd3;  ram[8'h42] = 32'(-7); ram[8'h44] = 32'd11;
        ram[8'h60] = 32'd9;  ram[8'h63] = 32'd4;   ram[8'h66] = 32'(-2);
        run_op("stride_a", 0, 32'h40, 32'h60, 2, 3, 32'h50, 3, 32'hFFFF_FFE9, 1'b0, 14, 1'b0);
        check_reads("stride_a", 32'h40, 32'h60, 2, 3, 3);
        run_op("stride_b", 1, 32'h40, 32'h60, 2, 3, 32'h51, 3, 32'hFFFF_FFE9, 1'b0, 20, 1'b0);
        check_reads("stride_b", 32'h40, 32'h60, 2, 3, 3);

        // Empty vector
        run_op("empty_a", 0, 32'h10, 32'h20, 1, 1, 32'h70, 0, 32'd0, 1'b0, 2, 1'b0);
        check("empty_a_no_reads", 64'(rd_log.size()), 64'd0);
        run_op("empty_b", 1, 32'h10, 32'h20, 1, 1, 32'h71, 0, 32'd0, 1'b0, 2, 1'b0);
        check("empty_b_no_reads", 64'(rd_log.size()), 64'd0);

        // Result out of 32-bit range: acc = 0x7FFFFFFE_00000002
        ram[8'h80] = 32'h7FFF_FFFF; ram[8'h81] = 32'h7FFF_FFFF;
        ram[8'h90] = 32'h7FFF_FFFF; ram[8'h91] = 32'h7FFF_FFFF;
        run_op("sat_trunc_a", 0, 32'h80, 32'h90, 1, 1, 32'h72, 2, 32'h0000_0002, 1'b1, 10, 1'b0);
        run_op("sat_clamp_b", 1, 32'h80, 32'h90, 1, 1, 32'h73, 2, 32'h7FFF_FFFF, 1'b1, 14, 1'b0);
        repeat (3) @(negedge clk);
        check("ovf_held_b", {63'd0, bus_b.overflow}, 64'd1);

        // Negative operands; a new start clears the held overflow
        ram[8'hA0] = 32'(-3); ram[8'hA1] = 32'd2;
        ram[8'hB0] = 32'd4;   ram[8'hB1] = 32'(-5);
        run_op("neg_b", 1, 32'hA0, 32'hB0, 1, 1, 32'h74, 2, 32'hFFFF_FFEA, 1'b0, 14, 1'b0);
        run_op("neg_a", 0, 32'hA0, 32'hB0, 1, 1, 32'h75, 2, 32'hFFFF_FFEA, 1'b0, 10, 1'b0);

        // Accumulator wrap: 2^62 + 2^62 overflows 64-bit signed to -2^63
        ram[8'hC0] = 32'h8000_0000; ram[8'hC1] = 32'h8000_0000;
        ram[8'hD0] = 32'h8000_0000; ram[8'hD1] = 32'h8000_0000;
        run_op("accwrap_a", 0, 32'hC0, 32'hD0, 1, 1, 32'h76, 2, 32'h0000_0000, 1'b1, 10, 1'b0);
        run_op("accwrap_b", 1, 32'hC0, 32'hD0, 1, 1, 32'h77, 2, 32'h8000_0000, 1'b1, 14, 1'b0);

        // Start held high through the whole op: exactly one op and one write
        run_op("hold_a", 0, 32'h10, 32'h20, 1, 1, 32'h32, 4, 32'd70, 1'b0, 18, 1'b1);
        repeat (6) @(negedge clk);
        check("hold_a_idle_busy", {63'd0, bus_a.busy}, 64'd0);
        check("hold_a_no_extra", 64'(exp_q.size()), 64'd0);

        // Reset while in MUL (cycle 3 for MULT_LAT=1)
        set_cfg(32'h10, 32'h20, 1, 1, 32'h34, 4);
        bus_a.start = 1'b1;
        @(negedge clk);
        bus_a.start = 1'b0;
        repeat (2) @(negedge clk);
        check("abort_busy_pre", {63'd0, bus_a.busy}, 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("abort_busy_post", {63'd0, bus_a.busy}, 64'd0);
        check("abort_done_post", {63'd0, bus_a.done}, 64'd0);
        check("abort_we_post", {63'd0, bus_a.mem_we}, 64'd0);
        rst = 1'b0;
        seen_done = 0;
        seen_we   = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus_a.done)   seen_done++;
            if (bus_a.mem_we) seen_we++;
        end
        check("abort_no_done", 64'(seen_done), 64'd0);
        check("abort_no_write", 64'(seen_we), 64'd0);
        check("abort_ram_kept", {32'd0, ram[8'h34]}, {32'd0, 32'hDEAD_0034});

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
